// File: rtl/arm_multicycle_ctrl.sv
// arm_multicycle_ctrl: multicycle ARM sequencer driving datapath selects and enables
module arm_multicycle_ctrl #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUControl,
  output logic        RegWrite,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic [3:0]  State
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_t;
  state_t state, next;
  logic [3:0] nzcv, cond, cmd, rd, dp_alu;
  logic [1:0] op;
  logic [5:0] funct;
  logic cond_ex, dp_ok, dp_arith, is_cmp, dp_write, pc_w, ir_w, rf_w, mem_w;
  logic unused_rn;
  assign cond = Instr[19:16];
  assign op = Instr[15:14];
  assign funct = Instr[13:8];
  assign cmd = funct[4:1];
  assign rd = Instr[3:0];
  assign unused_rn = ^Instr[7:4];
  assign is_cmp = cmd == 4'b1010;
  assign dp_write = dp_ok && !is_cmp;
  assign RegSrc = {op == 2'b01 && !funct[0], op == 2'b10};
  assign ImmSrc = op;
  assign State = state;
  assign PCWrite = pc_w & reset;
  assign IRWrite = ir_w & reset;
  assign RegWrite = rf_w & reset;
  assign MemWrite = mem_w & reset;
  // condition check against the stored flags
  always_comb begin
    case (cond)
      4'b0000: cond_ex = nzcv[2];
      4'b0001: cond_ex = !nzcv[2];
      4'b0010: cond_ex = nzcv[1];
      4'b0011: cond_ex = !nzcv[1];
      4'b0100: cond_ex = nzcv[3];
      4'b0101: cond_ex = !nzcv[3];
      4'b0110: cond_ex = nzcv[0];
      4'b0111: cond_ex = !nzcv[0];
      4'b1000: cond_ex = nzcv[1] && !nzcv[2];
      4'b1001: cond_ex = !nzcv[1] || nzcv[2];
      4'b1010: cond_ex = nzcv[3] == nzcv[0];
      4'b1011: cond_ex = nzcv[3] != nzcv[0];
      4'b1100: cond_ex = !nzcv[2] && nzcv[3] == nzcv[0];
      4'b1101: cond_ex = nzcv[2] || nzcv[3] != nzcv[0];
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
  // data-processing command to ALU operation; unsupported commands fall back to ADD
  always_comb begin
    dp_ok = 1'b1;
    dp_arith = 1'b0;
    dp_alu = 4'b0000;
    case (cmd)
      4'b0100: dp_arith = 1'b1;
      4'b0010: {dp_arith, dp_alu} = 5'b1_0001;
      4'b1010: {dp_arith, dp_alu} = 5'b1_0001;
      4'b0000: dp_alu = 4'b0010;
      4'b1100: dp_alu = 4'b0011;
      4'b0001: dp_alu = 4'b0100;
      4'b1101: dp_alu = 4'b0101;
      default: dp_ok = 1'b0;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else state <= next;
  end
  // flags capture at the end of an execute cycle; logical ops keep C and V
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) nzcv <= RESET_FLAGS;
    else if ((state == EXECR || state == EXECI) && dp_ok && (funct[0] || is_cmp))
      nzcv <= dp_arith ? ALUFlags : {ALUFlags[3:2], nzcv[1:0]};
  end
  // next state and Moore outputs
  always_comb begin
    next = FETCH;
    AdrSrc = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'b00;
    ALUControl = 4'b0000;
    pc_w = 1'b0;
    ir_w = 1'b0;
    rf_w = 1'b0;
    mem_w = 1'b0;
    case (state)
      FETCH: begin
        {ir_w, pc_w, ALUSrcA, ALUSrcB, ResultSrc} = 7'b111_10_10;
        next = DECODE;
      end
      DECODE: begin
        {ALUSrcA, ALUSrcB, ResultSrc} = 5'b1_10_10;
        next = !cond_ex ? FETCH : op == 2'b01 ? MEMADR : op == 2'b00 ? (funct[5] ? EXECI : EXECR)
             : op == 2'b10 ? BRANCH : FETCH;
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        ALUControl = funct[3] ? 4'b0000 : 4'b0001;
        next = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
        next = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        rf_w = 1'b1;
        pc_w = rd == 4'hf;
      end
      MEMWR: {AdrSrc, mem_w} = 2'b11;
      EXECR, EXECI: begin
        ALUSrcB = state == EXECI ? 2'b01 : 2'b00;
        ALUControl = dp_alu;
        next = ALUWB;
      end
      ALUWB: begin
        rf_w = dp_write;
        pc_w = dp_write && rd == 4'hf;
      end
      BRANCH: begin
        {ALUSrcB, ResultSrc, pc_w} = 5'b01_10_1;
        rf_w = funct[4];
      end
      default: next = FETCH;
    endcase
  end
endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// tb_arm_multicycle_ctrl: directed and random checks against a per-instruction cycle model
module tb_arm_multicycle_ctrl;
  logic clk = 1'b0, reset = 1'b0;
  logic [19:0] Instr = '0;
  logic [3:0] ALUFlags = '0;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0] ResultSrc, ALUSrcB, RegSrc, ImmSrc;
  logic [3:0] ALUControl, dbg_state_unused;
  int checks = 0, passes = 0;
  logic [3:0] flags;
  typedef struct {int pcw, mw, irw, rw, adr, a, b, alu, res;} step_t;
  step_t q[$];

  arm_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .PCWrite(PCWrite),
    .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .RegWrite(RegWrite),
    .RegSrc(RegSrc), .ImmSrc(ImmSrc), .State(dbg_state_unused)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input int exp);
    logic [3:0] e;
    e = exp[3:0];
    checks++;
    assert (obs === e) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
  endtask

  function automatic step_t st(int pcw, int mw, int irw, int rw, int adr, int a, int b, int alu, int res);
    step_t s;
    s = '{pcw, mw, irw, rw, adr, a, b, alu, res};
    return s;
  endfunction

  function automatic bit cond_ok(logic [3:0] c, logic [3:0] f);
    bit n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      0: return z;
      1: return !z;
      2: return cf;
      3: return !cf;
      4: return n;
      5: return !n;
      6: return v;
      7: return !v;
      8: return cf && !z;
      9: return !cf || z;
      10: return n == v;
      11: return n != v;
      12: return !z && n == v;
      13: return z || n != v;
      14: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int alu_of(logic [3:0] cmd);
    case (cmd)
      4'b0100: return 0;
      4'b0010, 4'b1010: return 1;
      4'b0000: return 2;
      4'b1100: return 3;
      4'b0001: return 4;
      4'b1101: return 5;
      default: return -1;
    endcase
  endfunction

  task automatic run_instr(input string name, input logic [19:0] ins, input logic [3:0] fl, input int limit);
    logic [1:0] op;
    logic [3:0] cmd;
    int ac, wr, rd15;
    op = ins[15:14];
    cmd = ins[12:9];
    rd15 = ins[3:0] == 4'hf ? 1 : 0;
    q.delete();
    q.push_back(st(1, 0, 1, 0, 0, 1, 2, 0, 2));
    q.push_back(st(0, 0, 0, 0, -1, 1, 2, 0, 2));
    if (cond_ok(ins[19:16], flags)) begin
      if (op == 2'b00) begin
        ac = alu_of(cmd);
        wr = (ac >= 0 && cmd != 4'b1010) ? 1 : 0;
        q.push_back(st(0, 0, 0, 0, -1, 0, ins[13] ? 1 : 0, ac < 0 ? 0 : ac, -1));
        q.push_back(st(wr & rd15, 0, 0, wr, -1, -1, -1, -1, 0));
        if (ac >= 0 && (ins[8] || cmd == 4'b1010)) begin
          if (ac <= 1) flags = fl;
          else flags[3:2] = fl[3:2];
        end
      end else if (op == 2'b01) begin
        q.push_back(st(0, 0, 0, 0, -1, 0, 1, ins[11] ? 0 : 1, -1));
        if (ins[8]) begin
          q.push_back(st(0, 0, 0, 0, 1, -1, -1, -1, 0));
          q.push_back(st(rd15, 0, 0, 1, -1, -1, -1, -1, 1));
        end else q.push_back(st(0, 1, 0, 0, 1, -1, -1, -1, -1));
      end else if (op == 2'b10) q.push_back(st(1, 0, 0, ins[12] ? 1 : 0, -1, 0, 1, 0, 2));
    end
    Instr = ins;
    ALUFlags = fl;
    for (int i = 0; i < q.size() && i < limit; i++) begin
      #1;
      chk($sformatf("%s c%0d PCWrite", name, i), {3'b0, PCWrite}, q[i].pcw);
      chk($sformatf("%s c%0d MemWrite", name, i), {3'b0, MemWrite}, q[i].mw);
      chk($sformatf("%s c%0d IRWrite", name, i), {3'b0, IRWrite}, q[i].irw);
      chk($sformatf("%s c%0d RegWrite", name, i), {3'b0, RegWrite}, q[i].rw);
      chk($sformatf("%s c%0d RegSrc", name, i), {2'b0, RegSrc}, {op == 2'b01 && !ins[8], op == 2'b10});
      chk($sformatf("%s c%0d ImmSrc", name, i), {2'b0, ImmSrc}, op);
      if (q[i].adr >= 0) chk($sformatf("%s c%0d AdrSrc", name, i), {3'b0, AdrSrc}, q[i].adr);
      if (q[i].a >= 0) chk($sformatf("%s c%0d ALUSrcA", name, i), {3'b0, ALUSrcA}, q[i].a);
      if (q[i].b >= 0) chk($sformatf("%s c%0d ALUSrcB", name, i), {2'b0, ALUSrcB}, q[i].b);
      if (q[i].alu >= 0) chk($sformatf("%s c%0d ALUControl", name, i), ALUControl, q[i].alu);
      if (q[i].res >= 0) chk($sformatf("%s c%0d ResultSrc", name, i), {2'b0, ResultSrc}, q[i].res);
      if (i + 1 == limit) break;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk_reset_enables(input string tag);
    chk({tag, " PCWrite"}, {3'b0, PCWrite}, 0);
    chk({tag, " IRWrite"}, {3'b0, IRWrite}, 0);
    chk({tag, " RegWrite"}, {3'b0, RegWrite}, 0);
    chk({tag, " MemWrite"}, {3'b0, MemWrite}, 0);
  endtask

  initial begin
    flags = 4'b0000;
    repeat (2) @(negedge clk);
    chk_reset_enables("por");
    reset = 1'b1;
    run_instr("adds_z", 20'hE0921, 4'b0100, 99);
    run_instr("beq_taken", 20'h0A000, 4'b0000, 99);
    run_instr("str_part", 20'hE5810, 4'b0000, 4);
    #2 reset = 1'b0;
    #1 chk_reset_enables("rst_mid_memwr");
    flags = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    chk_reset_enables("rst_held");
    reset = 1'b1;
    run_instr("beq_after_rst", 20'h0A000, 4'b0000, 99);
    run_instr("adds", 20'hE0921, 4'b0110, 99);
    run_instr("beq_z", 20'h0A000, 4'b0000, 99);
    run_instr("cmp", 20'hE1510, 4'b0110, 99);
    run_instr("bne", 20'h1A000, 4'b0000, 99);
    run_instr("ldr", 20'hE5110, 4'b0000, 99);
    run_instr("str", 20'hE5810, 4'b0000, 99);
    run_instr("bl", 20'hEB000, 4'b0000, 99);
    run_instr("add_pc", 20'hE280F, 4'b0000, 99);
    run_instr("never", 20'hF0921, 4'b1111, 99);
    run_instr("ands", 20'hE0101, 4'b1011, 99);
    run_instr("bcs", 20'h2A000, 4'b0000, 99);
    for (int k = 0; k < 300; k++) run_instr($sformatf("rnd%0d", k), 20'($urandom), 4'($urandom), 99);
    run_instr("nop_tail", 20'hEC000, 4'b0000, 99);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/arm_multicycle_ctrl.md
Name: arm_multicycle_ctrl

Overview:
Multicycle sequencer for the ARM datapath: one shared ALU and one unified instruction/data memory are reused across several cycles per instruction.
- Decodes the latched instruction (IR output) and evaluates condition codes against an internal NZCV register.
- Steps a Moore FSM that drives every datapath mux select and write enable.
- Sits between the datapath's IR/ALU and the enables of the PC, IR, register file and memory; replaces the single-cycle controller.

Parameters:
RESET_FLAGS, 4'b0000, value loaded into the internal {N,Z,C,V} register on reset.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
Instr  in  20  IR bits [31:12]: cond[31:28], op[27:26], funct[25:20], Rd[15:12].
ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle.
PCWrite  out  1  PC register enable.
AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
MemWrite  out  1  memory write enable.
IRWrite  out  1  IR load enable.
ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data register, 10 = ALUResult.
ALUSrcA  out  1  ALU A select: 0 = RD1, 1 = PC.
ALUSrcB  out  2  ALU B select: 00 = RD2, 01 = ExtImm, 10 = constant 4.
ALUControl  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 0100 EOR, 0101 MOV (pass B).
RegWrite  out  1  register file write enable.
RegSrc  out  2  bit0 = 1 reads R15 as Rn (branch); bit1 = 1 reads Rd as Rm (STR).
ImmSrc  out  2  extend format = op: 00 rotated imm8, 01 imm12, 10 imm24 (shifted by 2).
State  out  4  current FSM state, for debug/bench only.

Behaviour:
Reset (reset = 0, asynchronous):
- State = FETCH, NZCV = RESET_FLAGS.
- PCWrite, IRWrite, RegWrite and MemWrite are forced to 0 while reset is low.
- Reset mid-instruction abandons the instruction with no partial writes; the first edge after release performs FETCH.

States, with registered next state and Moore outputs (unlisted enables = 0, unlisted selects = don't care):
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1. Next state: DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10 (supplies PC+8 as R15).
  - CondEx false -> FETCH.
  - Otherwise op 01 -> MEMADR; op 00 with funct[5]=0 -> EXECR, funct[5]=1 -> EXECI; op 10 -> BRANCH; op 11 -> FETCH (treated as NOP).
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD if U (Instr[23]) = 1, else SUB. Next state: MEMRD if L (Instr[20]) = 1, else MEMWR.
- MEMRD: AdrSrc=1, ResultSrc=00. Next state: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. PCWrite=1 if Rd = 15. Next state: FETCH.
- MEMWR: AdrSrc=1, MemWrite=1. Next state: FETCH.
- EXECR / EXECI: ALUSrcA=0, ALUSrcB = 00 (EXECR) or 01 (EXECI); ALUControl from cmd Instr[24:21]:
  - 0100 -> ADD, 0010 -> SUB, 1010 (CMP) -> SUB, 0000 -> AND, 1100 -> ORR, 0001 -> EOR, 1101 -> MOV.
  - Any other cmd -> ADD with all writes suppressed.
  - Next state: ALUWB.
- ALUWB: ResultSrc=00; RegWrite=1 unless CMP or unsupported cmd; PCWrite=1 if Rd = 15 and RegWrite = 1. Next state: FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=1. RegWrite=1 only if L (Instr[24]) = 1 (BL; the datapath steers the write to R14). Next state: FETCH.
- Unused state encodings -> FETCH.

Flags:
- At the end of EXECR/EXECI, ALUFlags are captured if S (Instr[20]) = 1 or cmd = CMP.
- ADD/SUB/CMP update N, Z, C, V. AND/ORR/EOR/MOV update N, Z only; C and V are held.
- Flags never change in any other state.

CondEx (combinational, from the stored NZCV):
- 0000 EQ, 0001 NE, 0010 CS, 0011 CC, 0100 MI, 0101 PL, 0110 VS, 0111 VC.
- 1000 HI = C & !Z; 1001 LS; 1010 GE = N == V; 1011 LT; 1100 GT = !Z & (N == V); 1101 LE; 1110 AL = 1; 1111 = 0.

Cycle counts:
- Data-processing: 4. LDR: 5. STR: 4. B/BL: 3. Condition-failed instruction: 2.

Combinational outputs: RegSrc and ImmSrc are decoded from Instr every cycle, independent of state.

Test Plan:
1. Hold reset low mid-MEMWR, then release -> MemWrite = 0 during reset; State = FETCH; NZCV = 0000; first post-reset cycle shows PCWrite = IRWrite = 1.
2. ADDS R1,R2,R3 (Instr[31:12] = 0xE0921) with ALUFlags = 0110 -> states FETCH, DECODE, EXECR, ALUWB; RegWrite = 1 in ALUWB only; NZCV = 0110 afterwards.
3. CMP R1,R1 with ALUFlags = 0110, then BNE -> CMP gives RegWrite = 0 and NZCV = 0110; BNE goes DECODE -> FETCH (2 cycles) with PCWrite = 0 outside FETCH.
4. LDR R0,[R1,#-4] (Instr[31:12] = 0xE5110) -> MEMADR has ALUControl = SUB; AdrSrc = 1 in MEMRD; ResultSrc = 01 and RegWrite = 1 in MEMWB; 5 cycles total.
5. STR R0,[R1,#8] (Instr[31:12] = 0xE5810) -> RegSrc = 10; MemWrite = 1 for exactly one cycle (MEMWR); RegWrite never asserted; 4 cycles.
6. BL with cond = 1110, then ADD PC,R0,#0 (Rd = 15) -> BL gives PCWrite = 1 and RegWrite = 1 in BRANCH; the ADD gives PCWrite = 1 and RegWrite = 1 in ALUWB.
